// File: rtl/stat_counter_bank.sv
// Per-channel event counters with shadow snapshot, sticky overflow and halt freeze.
// Latency: counters update on the edge after an event; rd_data is registered (1 cycle).
// Backpressure: none; every event seen in RUN with en=1 is counted, FROZEN drops events.
module stat_counter_bank #(
  parameter int CHANNELS = 6,
  parameter int WIDTH    = 32,
  parameter int SEL_W    = 3,
  parameter int SATURATE = 0
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_en,
  input  logic                i_halt,
  input  logic [CHANNELS-1:0] i_event,
  input  logic                i_clr,
  input  logic                i_snap,
  input  logic [SEL_W-1:0]    i_sel,
  input  logic                i_live_sel,
  output logic [WIDTH-1:0]    o_rd_data,
  output logic [CHANNELS-1:0] o_ovf,
  output logic                o_halted
);

  typedef enum logic {ST_RUN, ST_FROZEN} state_t;

  localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};

  state_t              r_state;
  state_t              w_state_nxt;
  logic                w_count_ok;
  logic [WIDTH-1:0]    r_cnt    [CHANNELS];
  logic [WIDTH-1:0]    r_shadow [CHANNELS];
  logic [CHANNELS-1:0] r_ovf;
  logic [WIDTH-1:0]    r_rd_data;
  logic [WIDTH-1:0]    w_rd_nxt;

  // FSM state register; reset always returns to RUN
  always_ff @(posedge i_clk) begin
    if (!i_rst) r_state <= ST_RUN;
    else        r_state <= w_state_nxt;
  end

  // Next-state: clr beats halt; halt only matters from RUN, so the halt cycle itself still counts
  always_comb begin
    w_state_nxt = r_state;
    w_count_ok  = 1'b0;
    if (i_clr) begin
      w_state_nxt = ST_RUN;
    end else if (r_state == ST_RUN) begin
      w_count_ok = i_en;
      if (i_halt) w_state_nxt = ST_FROZEN;
    end
  end

  // Live counters and sticky overflow; clr zeroes both and wins over events
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      for (int i = 0; i < CHANNELS; i++) r_cnt[i] <= '0;
      r_ovf <= '0;
    end else if (i_clr) begin
      for (int i = 0; i < CHANNELS; i++) r_cnt[i] <= '0;
      r_ovf <= '0;
    end else if (w_count_ok) begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (i_event[i]) begin
          if (r_cnt[i] == CNT_MAX) begin
            r_ovf[i] <= 1'b1;
            if (SATURATE == 0) r_cnt[i] <= '0;
          end else begin
            r_cnt[i] <= r_cnt[i] + WIDTH'(1);
          end
        end
      end
    end
  end

  // Shadow copy takes the pre-edge live value; clr leaves shadows alone
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      for (int i = 0; i < CHANNELS; i++) r_shadow[i] <= '0;
    end else if (i_snap) begin
      for (int i = 0; i < CHANNELS; i++) r_shadow[i] <= r_cnt[i];
    end
  end

  // Readout mux by compare so out-of-range selects fall through to zero
  always_comb begin
    w_rd_nxt = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (i_sel == SEL_W'(i)) w_rd_nxt = i_live_sel ? r_cnt[i] : r_shadow[i];
    end
  end

  // Registered readout
  always_ff @(posedge i_clk) begin
    if (!i_rst) r_rd_data <= '0;
    else        r_rd_data <= w_rd_nxt;
  end

  assign o_rd_data = r_rd_data;
  assign o_ovf     = r_ovf;
  assign o_halted  = (r_state == ST_FROZEN);

endmodule

// File: doc/stat_counter_bank.md
STAT_COUNTER_BANK -- requirements
Module: stat_counter_bank

Interface
REQ-001 Parameter CHANNELS, default 6; number of independent event counters (1..16).
REQ-002 Parameter WIDTH, default 32; counter and read-data width in bits (8..32).
REQ-003 Parameter SEL_W, default 3; readout select width; must satisfy 2**SEL_W >= CHANNELS.
REQ-004 Parameter SATURATE, default 0; 0 = counters wrap at max, 1 = counters saturate at max.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst  input  1  reset, synchronous and active-low.
REQ-007 en  input  1  global count enable.
REQ-008 halt  input  1  program-halt indication; freezes counting (see Function).
REQ-009 event  input  CHANNELS  per-channel event strobe, one count per cycle high.
REQ-010 clr  input  1  synchronous clear of live counters, overflow flags and halt state.
REQ-011 snap  input  1  copy all live counters into shadow registers.
REQ-012 sel  input  SEL_W  channel index for readout.
REQ-013 live_sel  input  1  readout source: 1 = live counter, 0 = shadow register.
REQ-014 rd_data  output  WIDTH  registered readout value.
REQ-015 ovf  output  CHANNELS  sticky per-channel overflow flag.
REQ-016 halted  output  1  high while FSM is in FROZEN.

Function
REQ-017 FSM SHALL have two states: RUN and FROZEN; RUN -> FROZEN when halt=1 and clr=0; FROZEN -> RUN only on clr=1 or reset; halt while FROZEN has no effect.
REQ-018 In RUN, counter i SHALL increment by 1 on each edge where en=1 and event[i]=1; channels are independent and may all increment in the same cycle.
REQ-019 Events sampled in the cycle halt first asserts SHALL still be counted; no counter changes in any cycle while in FROZEN.
REQ-020 en=0 SHALL hold all counters without changing FSM state.
REQ-021 SATURATE=0: counter at 2**WIDTH-1 incrementing SHALL become 0 and set ovf[i].
REQ-022 SATURATE=1: counter at 2**WIDTH-1 SHALL hold its value and set ovf[i] on any attempted increment.
REQ-023 ovf[i] SHALL remain set until clr or reset.
REQ-024 clr SHALL zero all live counters and ovf, force RUN, and take priority over event and halt in the same cycle; shadow registers are unaffected by clr.
REQ-025 snap SHALL load each shadow register with the live value present before that edge (pre-increment, pre-clear); snap is honoured in both RUN and FROZEN.
REQ-026 rd_data SHALL have one-cycle latency: value on the edge after sel/live_sel are sampled, reflecting counter/shadow state before that edge.
REQ-027 sel >= CHANNELS SHALL yield rd_data = 0.
REQ-028 halted SHALL be a registered FSM output, high in the cycle after the halt edge.

Reset
REQ-029 On rst=0 at a rising edge: all live counters, shadow registers, ovf, rd_data = 0; halted = 0; FSM = RUN.
REQ-030 Reset SHALL take priority over clr, snap, halt and event; reset asserted mid-count discards all accumulated values.
REQ-031 After rst returns high, counting SHALL resume on the first edge with en=1 and an event.

Verification
REQ-032 Reset then en=1, event=6'b000011 for 10 cycles, sel=0, live_sel=1 -> rd_data=10 one cycle later; sel=2 -> rd_data=0.
REQ-033 WIDTH=8, SATURATE=0, channel 0 preloaded to 255 by 255 events, one more event -> counter 0, ovf[0]=1; SATURATE=1 same stimulus -> counter 255, ovf[0]=1.
REQ-034 Count channel 1 to 5, assert halt with event[1]=1 same cycle -> counter 6, halted=1 next cycle; 20 further events -> counter stays 6; clr -> counter 0, halted=0.
REQ-035 Counter 0 at 7, snap and event[0] same cycle -> shadow 7, live 8; then clr -> live 0, shadow still 7 via live_sel=0.
REQ-036 clr and event[3] same cycle with counter at 4 -> counter 0 (clr wins); rst=0 during active counting -> all outputs 0 next cycle.
REQ-037 sel=7 with CHANNELS=6 -> rd_data=0 for both live_sel values.
